uart_resp_packer: RTL and testbench

UART_RESP_PACKER -- requirements
Module: uart_resp_packer

---
 rtl/uart_resp_packer.sv | 176 +++++++++++++++++
 tb/tb_uart_resp_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_resp_packer.sv
// Response framer: captures a function code plus ten payload bytes and streams a
// 14-byte frame (two header bytes, function, payload, additive checksum) over a valid/ready byte port.
module uart_resp_packer #(
  parameter logic [7:0] _HEAD0 = 8'h55,
  parameter logic [7:0] _HEAD1 = 8'hAA
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       resp_req,
  input  logic [7:0] resp_func,
  input  logic [7:0] resp_data1,
  input  logic [7:0] resp_data2,
  input  logic [7:0] resp_data3,
  input  logic [7:0] resp_data4,
  input  logic [7:0] resp_data5,
  input  logic [7:0] resp_data6,
  input  logic [7:0] resp_data7,
  input  logic [7:0] resp_data8,
  input  logic [7:0] resp_data9,
  input  logic [7:0] resp_data10,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       req_drop
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd13;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  func_q, func_d;
  logic [79:0] data_q, data_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        req_drop_q, req_drop_d;
  logic [79:0] data_in_s;
  logic        accept_s;

  // Modulo-256 sum of the function code and all ten payload bytes.
  function automatic logic [7:0] calc_chk(input logic [7:0] func, input logic [79:0] data);
    logic [7:0] s;
    s = func;
    for (int n = 0; n < 10; n++) begin
      s = s + data[n*8 +: 8];
    end
    return s;
  endfunction

  // Byte at frame position i, built from the captured registers only.
  function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [7:0] func,
                                            input logic [79:0] data, input logic [7:0] chk);
    logic [3:0] k;
    logic [7:0] b;
    k = i - 4'd3;
    b = 8'h00;
    case (i)
      4'd0:  b = _HEAD0;
      4'd1:  b = _HEAD1;
      4'd2:  b = func;
      4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
             b = data[{k, 3'b000} +: 8];
      4'd13: b = chk;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign data_in_s = {resp_data10, resp_data9, resp_data8, resp_data7, resp_data6,
                      resp_data5, resp_data4, resp_data3, resp_data2, resp_data1};
  assign accept_s  = tx_valid_q & tx_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    func_d       = func_q;
    data_d       = data_q;
    chk_d        = chk_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    req_drop_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (resp_req) begin
          func_d     = resp_func;
          data_d     = data_in_s;
          chk_d      = calc_chk(resp_func, data_in_s);
          idx_d      = 4'd0;
          state_d    = SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = _HEAD0;
          busy_d     = 1'b1;
        end else begin
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          busy_d     = 1'b0;
        end
      end
      SEND: begin
        // Any request seen while a frame is in flight, including on the final accept, is dropped.
        if (resp_req) begin
          req_drop_d = 1'b1;
        end else begin
          req_drop_d = 1'b0;
        end
        if (accept_s) begin
          if (idx_q == LAST_IDX) begin
            state_d      = IDLE;
            idx_d        = 4'd0;
            tx_valid_d   = 1'b0;
            tx_data_d    = 8'h00;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = frame_byte(idx_q + 4'd1, func_q, data_q, chk_q);
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        idx_d      = 4'd0;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Single register bank for FSM state, captured frame contents and all outputs.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      func_q       <= 8'h00;
      data_q       <= 80'h0;
      chk_q        <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      req_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      func_q       <= func_d;
      data_q       <= data_d;
      chk_q        <= chk_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      req_drop_q   <= req_drop_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign req_drop   = req_drop_q;

endmodule

// File: tb/tb_uart_resp_packer.sv
// Bench for uart_resp_packer: a frame-queue reference model checked on every falling
// edge, plus literal frame expectations per directed scenario.
module tb_uart_resp_packer;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic       resp_req = 1'b0;
  logic [7:0] resp_func = 8'h00;
  logic [7:0] d [1:10];
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       req_drop;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int drop_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_drop = 1'b0;

  always #5 clk_50M = ~clk_50M;

  uart_resp_packer dut (
    .clk_50M(clk_50M), .rst(rst), .resp_req(resp_req), .resp_func(resp_func),
    .resp_data1(d[1]), .resp_data2(d[2]), .resp_data3(d[3]), .resp_data4(d[4]),
    .resp_data5(d[5]), .resp_data6(d[6]), .resp_data7(d[7]), .resp_data8(d[8]),
    .resp_data9(d[9]), .resp_data10(d[10]),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .req_drop(req_drop)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chkint(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model with the inputs due at the next rising edge.
  always @(negedge clk_50M) begin
    int sum;
    chk1("tx_valid", tx_valid, m_busy);
    chk8("tx_data", tx_data, m_busy ? exp_q[0] : 8'h00);
    chk1("busy", busy, m_busy);
    chk1("frame_done", frame_done, m_done);
    chk1("req_drop", req_drop, m_drop);
    if (frame_done === 1'b1) done_cnt++;
    if (req_drop === 1'b1) drop_cnt++;
    if (!rst && tx_valid === 1'b1 && tx_ready) log_q.push_back(tx_data);
    m_done = 1'b0;
    m_drop = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (resp_req) m_drop = 1'b1;
      if (tx_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (resp_req) begin
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back(resp_func);
      sum = int'(resp_func);
      for (int i = 1; i <= 10; i++) begin
        exp_q.push_back(d[i]);
        sum = sum + int'(d[i]);
      end
      exp_q.push_back(8'(sum % 256));
      m_busy = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic set_frame(input logic [7:0] f, input logic [7:0] b);
    resp_func = f;
    for (int i = 1; i <= 10; i++) d[i] = 8'(int'(b) + i - 1);
  endtask

  task automatic start_scn();
    log_q.delete();
    done_cnt = 0;
    drop_cnt = 0;
  endtask

  // Literal frame: 55 AA f b b+1 .. b+9 c, with c worked out by hand per scenario.
  task automatic chk_frame(input string name, input logic [7:0] f, input logic [7:0] b,
                           input logic [7:0] c);
    logic [7:0] e [14];
    e[0] = 8'h55;
    e[1] = 8'hAA;
    e[2] = f;
    for (int i = 0; i < 10; i++) e[3+i] = 8'(int'(b) + i);
    e[13] = c;
    chkint({name, "_len"}, log_q.size(), 14);
    for (int i = 0; i < 14; i++) begin
      if (log_q.size() > i) chk8($sformatf("%s_byte%0d", name, i), log_q[i], e[i]);
    end
  endtask

  task automatic pulse_req();
    resp_req = 1'b1;
    step();
    resp_req = 1'b0;
  endtask

  initial begin
    for (int i = 1; i <= 10; i++) d[i] = 8'h00;
    step();
    step();
    chk1("reset_valid", tx_valid, 1'b0);
    chk8("reset_data", tx_data, 8'h00);
    chk1("reset_busy", busy, 1'b0);
    rst = 1'b0;
    step();

    // Scenario 1: continuous ready, 14 consecutive bytes then frame_done.
    start_scn();
    tx_ready = 1'b1;
    set_frame(8'h01, 8'h01);
    pulse_req();
    chk8("s1_first", tx_data, 8'h55);
    for (int c = 0; c < 14; c++) step();
    chk1("s1_done_pulse", frame_done, 1'b1);
    step();
    chk1("s1_done_single", frame_done, 1'b0);
    chk_frame("s1", 8'h01, 8'h01, 8'h38);
    chkint("s1_done_cnt", done_cnt, 1);

    // Scenario 2: ready toggling 1-0-1-0.
    start_scn();
    set_frame(8'h01, 8'h01);
    pulse_req();
    for (int c = 0; c < 32; c++) begin
      tx_ready = (c % 2 == 0);
      step();
    end
    tx_ready = 1'b1;
    step();
    chk_frame("s2", 8'h01, 8'h01, 8'h38);
    chkint("s2_done_cnt", done_cnt, 1);

    // Scenario 3: checksum wrap.
    start_scn();
    resp_func = 8'hFF;
    for (int i = 1; i <= 10; i++) d[i] = 8'hFF;
    pulse_req();
    for (int c = 0; c < 16; c++) step();
    chkint("s3_len", log_q.size(), 14);
    if (log_q.size() == 14) chk8("s3_chk", log_q[13], 8'hF5);

    // Scenario 4: requests during the frame and on the final accept are dropped.
    start_scn();
    set_frame(8'h20, 8'h21);
    pulse_req();
    set_frame(8'h77, 8'h77);
    for (int c = 1; c <= 18; c++) begin
      resp_req = (c == 5 || c == 14);
      step();
    end
    resp_req = 1'b0;
    chk_frame("s4", 8'h20, 8'h21, 8'h97);
    chkint("s4_drops", drop_cnt, 2);
    chkint("s4_done_cnt", done_cnt, 1);
    chk1("s4_idle", busy, 1'b0);

    // Scenario 5: reset while byte 7 is offered.
    start_scn();
    set_frame(8'h20, 8'h21);
    pulse_req();
    for (int c = 1; c <= 7; c++) step();
    chk8("s5_byte7", tx_data, 8'h25);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("s5_rst_valid", tx_valid, 1'b0);
    chk1("s5_rst_busy", busy, 1'b0);
    for (int c = 0; c < 3; c++) step();
    chkint("s5_no_done", done_cnt, 0);
    chkint("s5_partial_len", log_q.size(), 7);
    log_q.delete();
    set_frame(8'h02, 8'h01);
    pulse_req();
    for (int c = 0; c < 16; c++) step();
    chk_frame("s5_new", 8'h02, 8'h01, 8'h39);
    chkint("s5_done_cnt", done_cnt, 1);

    // Scenario 6: inputs scrambled every cycle after capture.
    start_scn();
    set_frame(8'h10, 8'h11);
    pulse_req();
    for (int c = 0; c < 16; c++) begin
      resp_func = 8'($urandom_range(0, 255));
      for (int i = 1; i <= 10; i++) d[i] = 8'($urandom_range(0, 255));
      step();
    end
    chk_frame("s6", 8'h10, 8'h11, 8'hE7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
